// File: rtl/aes_round_ctrl_if.sv
// Host-side handshake bundle for the AES round controller: block request in,
// ciphertext-ready out.
interface aes_round_ctrl_if;
  // A transfer happens on a rising clk edge where valid && ready are both high.
  // A producer holds valid (and its meaning) until that edge. Ready may be high
  // or low at any time and never depends combinationally on valid.
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/aes_round_ctrl.sv
// Control FSM that sequences one AES encryption block: load, NR paced rounds,
// then hold the result until the consumer takes it. Carries no data.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int KEY_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  bus,
    input  logic             abort,
    output logic             ld_state,
    output logic             key_start,
    output logic             rnd_en,
    output logic [3:0]       rnd_idx,
    output logic             last_rnd,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [1:0]       dbg_state
);

    localparam int WW = $clog2(KEY_LAT) + 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(KEY_LAT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_n;
    logic [WW-1:0]    wait_cnt, wait_n;
    logic [3:0]       idx_n;
    logic [CNT_W-1:0] blk_n;

    assign dbg_state = state;

    // in_ready and out_valid are registered, so inside IDLE in_ready is known
    // high and inside DONE out_valid is known high.
    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        idx_n   = rnd_idx;
        blk_n   = blk_cnt;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_n = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = 4'd0;
                end else begin
                    state_n = ROUND;
                    wait_n  = '0;
                    idx_n   = 4'd1;
                end
            end
            ROUND: begin
                if (abort) begin
                    state_n = IDLE;
                    wait_n  = '0;
                    idx_n   = 4'd0;
                end else if (wait_cnt == WAIT_MAX) begin
                    wait_n = '0;
                    if (rnd_idx == IDX_LAST) state_n = DONE;
                    else                     idx_n   = rnd_idx + 4'd1;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = 4'd0;
                end else if (bus.out_ready) begin
                    state_n = IDLE;
                    idx_n   = 4'd0;
                    blk_n   = blk_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes are computed from the next-state values so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            rnd_idx       <= 4'd0;
            blk_cnt       <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            ld_state      <= 1'b0;
            key_start     <= 1'b0;
            rnd_en        <= 1'b0;
            last_rnd      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            wait_cnt      <= wait_n;
            rnd_idx       <= idx_n;
            blk_cnt       <= blk_n;
            bus.in_ready  <= (state_n == IDLE);
            bus.out_valid <= (state_n == DONE);
            ld_state      <= (state_n == LOAD);
            key_start     <= (state_n == LOAD);
            rnd_en        <= (state_n == ROUND) && (wait_n == WAIT_MAX);
            last_rnd      <= (state_n == ROUND) && (wait_n == WAIT_MAX) && (idx_n == IDX_LAST);
            busy          <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a KEY_LAT=1 instance for the main flows
// and a KEY_LAT=3 instance for round pacing.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus0 ();
  aes_round_ctrl_if bus1 ();

  logic       abort0, ld_state0, key_start0, rnd_en0, last_rnd0, busy0;
  logic [3:0] rnd_idx0;
  logic [7:0] blk_cnt0;
  logic [1:0] dbg0;
  logic       abort1, ld_state1, key_start1, rnd_en1, last_rnd1, busy1;
  logic [3:0] rnd_idx1;
  logic [7:0] blk_cnt1;
  logic [1:0] dbg1;

  aes_round_ctrl #(.NR(10), .KEY_LAT(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .abort(abort0),
    .ld_state(ld_state0), .key_start(key_start0), .rnd_en(rnd_en0),
    .rnd_idx(rnd_idx0), .last_rnd(last_rnd0), .busy(busy0),
    .blk_cnt(blk_cnt0), .dbg_state(dbg0)
  );

  aes_round_ctrl #(.NR(10), .KEY_LAT(3), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .abort(abort1),
    .ld_state(ld_state1), .key_start(key_start1), .rnd_en(rnd_en1),
    .rnd_idx(rnd_idx1), .last_rnd(last_rnd1), .busy(busy1),
    .blk_cnt(blk_cnt1), .dbg_state(dbg1)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int pulses;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full block on u0 with immediate out_ready; returns rnd_en pulses seen.
  task automatic run_block(output int n);
    n = 0;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (rnd_en0) n++;
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; abort0 = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; abort1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Post-reset idle state
    check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_rnd_idx", 32'(rnd_idx0), 32'd0);
    check("rst_blk_cnt", 32'(blk_cnt0), 32'd0);
    check("rst_dbg", 32'(dbg0), 32'd0);

    // Nominal block, KEY_LAT=1: transfer at cycle 0
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    check("nom_ld_state", 32'(ld_state0), 32'd1);
    check("nom_key_start", 32'(key_start0), 32'd1);
    check("nom_load_idx", 32'(rnd_idx0), 32'd0);
    check("nom_load_in_ready", 32'(bus0.in_ready), 32'd0);
    check("nom_load_busy", 32'(busy0), 32'd1);
    check("nom_load_rnd_en", 32'(rnd_en0), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("nom_rnd_en", 32'(rnd_en0), 32'd1);
      check("nom_rnd_idx", 32'(rnd_idx0), 32'(i));
      check("nom_last_rnd", 32'(last_rnd0), (i == 10) ? 32'd1 : 32'd0);
      check("nom_ld_off", 32'(ld_state0), 32'd0);
    end
    tick();
    check("nom_out_valid", 32'(bus0.out_valid), 32'd1);
    check("nom_done_rnd_en", 32'(rnd_en0), 32'd0);
    check("nom_dbg_done", 32'(dbg0), 32'd3);

    // Backpressure in DONE with in_valid pulses ignored
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid = i[0];
      tick();
      check("bp_out_valid", 32'(bus0.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus0.in_ready), 32'd0);
      check("bp_blk_cnt", 32'(blk_cnt0), 32'd0);
      check("bp_rnd_idx", 32'(rnd_idx0), 32'd10);
    end
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    check("hs_blk_cnt", 32'(blk_cnt0), 32'd1);
    check("hs_out_valid", 32'(bus0.out_valid), 32'd0);
    check("hs_in_ready", 32'(bus0.in_ready), 32'd1);
    check("hs_rnd_idx", 32'(rnd_idx0), 32'd0);

    // KEY_LAT=3 pacing on u1: transfer at cycle 0
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check("kl3_ld_state", 32'(ld_state1), 32'd1);
    check("kl3_key_start", 32'(key_start1), 32'd1);
    check("kl3_busy", 32'(busy1), 32'd1);
    check("kl3_in_ready", 32'(bus1.in_ready), 32'd0);
    for (int c = 2; c <= 31; c++) begin
      tick();
      check("kl3_rnd_en", 32'(rnd_en1), (c >= 4 && (c - 4) % 3 == 0) ? 32'd1 : 32'd0);
      check("kl3_rnd_idx", 32'(rnd_idx1), 32'((c - 2) / 3 + 1));
      check("kl3_last_rnd", 32'(last_rnd1), (c == 31) ? 32'd1 : 32'd0);
    end
    tick();
    check("kl3_out_valid", 32'(bus1.out_valid), 32'd1);
    check("kl3_dbg_done", 32'(dbg1), 32'd3);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("kl3_blk_cnt", 32'(blk_cnt1), 32'd1);

    // Abort during round 5
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ab_idx5", 32'(rnd_idx0), 32'd5);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("ab_busy", 32'(busy0), 32'd0);
    check("ab_in_ready", 32'(bus0.in_ready), 32'd1);
    check("ab_rnd_idx", 32'(rnd_idx0), 32'd0);
    check("ab_out_valid", 32'(bus0.out_valid), 32'd0);
    check("ab_blk_cnt", 32'(blk_cnt0), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("ab_no_out_valid", 32'(bus0.out_valid), 32'd0);
    end

    // Abort in IDLE does not block an accept
    abort0 = 1'b1;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    check("ab_idle_accept", 32'(ld_state0), 32'd1);
    tick();
    abort0 = 1'b0;
    check("ab_load_idle", 32'(dbg0), 32'd0);

    // Abort wins over a same-cycle output handshake
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("abhs_out_valid", 32'(bus0.out_valid), 32'd1);
    abort0 = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    abort0 = 1'b0;
    bus0.out_ready = 1'b0;
    check("abhs_blk_cnt", 32'(blk_cnt0), 32'd1);
    check("abhs_out_valid_off", 32'(bus0.out_valid), 32'd0);
    check("abhs_in_ready", 32'(bus0.in_ready), 32'd1);

    // Asynchronous reset in round 5
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ar_idx5", 32'(rnd_idx0), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("ar_rnd_en", 32'(rnd_en0), 32'd0);
    check("ar_ld_state", 32'(ld_state0), 32'd0);
    check("ar_key_start", 32'(key_start0), 32'd0);
    check("ar_last_rnd", 32'(last_rnd0), 32'd0);
    check("ar_busy", 32'(busy0), 32'd0);
    check("ar_in_ready", 32'(bus0.in_ready), 32'd1);
    check("ar_rnd_idx", 32'(rnd_idx0), 32'd0);
    check("ar_blk_cnt", 32'(blk_cnt0), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Counter wrap after 256 blocks
    for (int b = 0; b < 255; b++) run_block(pulses);
    check("wrap_255", 32'(blk_cnt0), 32'd255);
    run_block(pulses);
    check("wrap_0", 32'(blk_cnt0), 32'd0);
    run_block(pulses);
    check("wrap_pulses", 32'(pulses), 32'd10);
    check("wrap_next", 32'(blk_cnt0), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
